// File: rtl/lut_delay_block.sv
// rtl/lut_delay_block.sv - programmable LUT, output mode and primed delay line
// Optional rising-edge counter on OUT_o enabled by LUT_DELAY_EDGE_COUNT_EN.
module lut_delay_block #(
  parameter int NUM_IN = 3,
  parameter int DLY_W  = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_IN-1:0] INP_i,
  input  logic [31:0]       FUNC,
  input  logic              FUNC_wstb,
  input  logic [1:0]        MODE,
  input  logic              MODE_wstb,
  input  logic [DLY_W-1:0]  DELAY,
  input  logic              DELAY_wstb,
  output logic              OUT_o,
  output logic              BUSY_o
`ifdef LUT_DELAY_EDGE_COUNT_EN
  ,
  output logic [31:0]       EDGES_o
`endif
);

  localparam int DEPTH = 1 << DLY_W;
  localparam logic [DLY_W-1:0] DLY_ONE = {{(DLY_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_LEVEL  = 2'd0;
  localparam logic [1:0] MODE_RISE   = 2'd1;
  localparam logic [1:0] MODE_FALL   = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  logic             lut_q, lut_d;
  logic             prev_q;
  logic             tog_q, tog_d;
  logic             m_q, m_d;
  logic             out_q, out_d;
  logic             rise, fall;
  logic [DLY_W-1:0] wptr_q;
  logic [DLY_W-1:0] delay_q;
  logic [DLY_W-1:0] prime_q, prime_d;
  logic [DLY_W-1:0] rd_addr;
  logic             mem_q [DEPTH];

  // The table is sampled live; the strobe carries no extra meaning here.
  logic unused_inputs;
  assign unused_inputs = FUNC_wstb ^ (^FUNC);

  assign lut_d = FUNC[INP_i];

  always_comb begin
    rise    = lut_q & ~prev_q;
    fall    = ~lut_q & prev_q;
    tog_d   = tog_q ^ ((MODE == MODE_TOGGLE) & rise);
    m_d     = lut_q;
    case (MODE)
      MODE_LEVEL:  m_d = lut_q;
      MODE_RISE:   m_d = rise;
      MODE_FALL:   m_d = fall;
      MODE_TOGGLE: m_d = tog_d;
      default:     m_d = lut_q;
    endcase
    prime_d = (|prime_q) ? (prime_q - DLY_ONE) : prime_q;
    rd_addr = wptr_q - delay_q;
    // Stale ring entries are hidden until every slot in the window is fresh.
    if (|prime_q)
      out_d = 1'b0;
    else if (delay_q == '0)
      out_d = m_q;
    else
      out_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lut_q   <= 1'b0;
      prev_q  <= 1'b0;
      tog_q   <= 1'b0;
      m_q     <= 1'b0;
      out_q   <= 1'b0;
      wptr_q  <= '0;
      delay_q <= DELAY;
      prime_q <= DELAY;
    end else begin
      lut_q  <= lut_d;
      prev_q <= lut_q;
      tog_q  <= MODE_wstb ? 1'b0 : tog_d;
      m_q    <= m_d;
      out_q  <= out_d;
      wptr_q <= wptr_q + DLY_ONE;
      if (DELAY_wstb) begin
        delay_q <= DELAY;
        prime_q <= DELAY;
      end else begin
        prime_q <= prime_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q[wptr_q] <= m_q;
  end

  assign OUT_o  = out_q;
  assign BUSY_o = |prime_q;

`ifdef LUT_DELAY_EDGE_COUNT_EN
  logic        out_d1_q;
  logic [31:0] edges_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_d1_q <= 1'b0;
      edges_q  <= '0;
    end else begin
      out_d1_q <= out_q;
      if (out_q & ~out_d1_q & ~(&edges_q))
        edges_q <= edges_q + 32'd1;
    end
  end

  assign EDGES_o = edges_q;
`else
  // default build carries no edge counter
`endif

endmodule

// File: tb/tb_lut_delay_block.sv
// tb/tb_lut_delay_block.sv - randomized check of lut_delay_block against a history-based model
module tb_lut_delay_block;

  localparam int NUM_IN = 3;
  localparam int DLY_W  = 5;
  localparam int HIST   = 2048;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [NUM_IN-1:0] INP_i;
  logic [31:0]       FUNC;
  logic              FUNC_wstb;
  logic [1:0]        MODE;
  logic              MODE_wstb;
  logic [DLY_W-1:0]  DELAY;
  logic              DELAY_wstb;
  logic              OUT_o;
  logic              BUSY_o;
`ifdef LUT_DELAY_EDGE_COUNT_EN
  logic [31:0]       EDGES_o;
`endif

  lut_delay_block #(.NUM_IN(NUM_IN), .DLY_W(DLY_W)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .INP_i      (INP_i),
    .FUNC       (FUNC),
    .FUNC_wstb  (FUNC_wstb),
    .MODE       (MODE),
    .MODE_wstb  (MODE_wstb),
    .DELAY      (DELAY),
    .DELAY_wstb (DELAY_wstb),
    .OUT_o      (OUT_o),
    .BUSY_o     (BUSY_o)
`ifdef LUT_DELAY_EDGE_COUNT_EN
    ,
    .EDGES_o    (EDGES_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc   = 4;

  // Histories indexed by edge number: table output, mode value, block output.
  bit lut_h [HIST];
  bit mv_h  [HIST];
  bit out_h [HIST];
  bit inp_h [HIST];
  bit tog_m;
  int d_m = 0;
  int p_m = 0;
  bit seen_reset = 0;
  logic [31:0] edges_m;
  logic exp_out, exp_busy;

  task automatic step();
    bit rise, fall, tn, mv;
    @(posedge clk_i);
    cyc++;
    inp_h[cyc] = INP_i[0];
    if (reset_i) begin
      lut_h[cyc] = 0;
      mv_h[cyc]  = 0;
      out_h[cyc] = 0;
      tog_m      = 0;
      d_m        = int'(DELAY);
      p_m        = cyc;
      edges_m    = 0;
      seen_reset = 1;
    end else begin
      if (cyc > p_m && cyc <= p_m + d_m)
        out_h[cyc] = 0;
      else
        out_h[cyc] = mv_h[cyc - 1 - d_m];
      if (out_h[cyc-1] && !out_h[cyc-2] && edges_m != 32'hFFFF_FFFF)
        edges_m = edges_m + 1;
      rise = lut_h[cyc-1] && !lut_h[cyc-2];
      fall = !lut_h[cyc-1] && lut_h[cyc-2];
      tn   = (MODE == 2'd3) ? (tog_m ^ rise) : tog_m;
      case (MODE)
        2'd0:    mv = lut_h[cyc-1];
        2'd1:    mv = rise;
        2'd2:    mv = fall;
        default: mv = tn;
      endcase
      mv_h[cyc]  = mv;
      tog_m      = MODE_wstb ? 1'b0 : tn;
      lut_h[cyc] = ((FUNC >> INP_i) & 32'd1) != 0;
      if (DELAY_wstb) begin
        d_m = int'(DELAY);
        p_m = cyc;
      end
    end
    exp_out  = out_h[cyc];
    exp_busy = (cyc - p_m) < d_m;
    #1;
    if (seen_reset) begin
      tests++;
      assert (OUT_o === exp_out) else begin
        fails++;
        $error("FAIL out edge=%0d got=%b exp=%b", cyc, OUT_o, exp_out);
      end
      tests++;
      assert (BUSY_o === exp_busy) else begin
        fails++;
        $error("FAIL busy edge=%0d got=%b exp=%b", cyc, BUSY_o, exp_busy);
      end
`ifdef LUT_DELAY_EDGE_COUNT_EN
      tests++;
      assert (EDGES_o === edges_m) else begin
        fails++;
        $error("FAIL edges edge=%0d got=%0d exp=%0d", cyc, EDGES_o, edges_m);
      end
`endif
    end
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      INP_i = NUM_IN'($urandom());
      step();
    end
  endtask

  task automatic strobe_delay(input logic [DLY_W-1:0] d);
    DELAY = d;
    DELAY_wstb = 1'b1;
    INP_i = NUM_IN'($urandom());
    step();
    DELAY_wstb = 1'b0;
  endtask

  task automatic strobe_mode(input logic [1:0] m);
    MODE = m;
    MODE_wstb = 1'b1;
    INP_i = NUM_IN'($urandom());
    step();
    MODE_wstb = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; FUNC = 32'h80; FUNC_wstb = 1'b0; MODE = 2'd0; MODE_wstb = 1'b0;
    DELAY = '0; DELAY_wstb = 1'b0; INP_i = '0;
    step(); step();
    reset_i = 1'b0;

    // level mode, no delay
    INP_i = 3'd7; step(); step(); step();
    INP_i = 3'd3; step(); step(); step();
    rand_steps(20);
    FUNC = $urandom(); FUNC_wstb = 1'b1; INP_i = NUM_IN'($urandom()); step(); FUNC_wstb = 1'b0;
    rand_steps(20);

    // delay of 5 with priming, then DELAY changes without strobe
    FUNC = 32'h80;
    strobe_delay(5'd5);
    rand_steps(10);
    INP_i = 3'd7; step(); INP_i = 3'd0; rand_steps(20);
    DELAY = 5'd17;
    rand_steps(10);

    // edge modes; simultaneous MODE and DELAY strobes
    FUNC = 32'h0000_00F0;
    MODE = 2'd1; MODE_wstb = 1'b1; DELAY = '0; DELAY_wstb = 1'b1;
    INP_i = 3'd0; step();
    MODE_wstb = 1'b0; DELAY_wstb = 1'b0;
    INP_i = 3'd7; step(); step(); step(); step();
    rand_steps(25);
    MODE = 2'd2;
    rand_steps(30);

    // toggle mode with mid-stream mode strobes
    strobe_mode(2'd3);
    for (int k = 0; k < 3; k++) begin
      INP_i = 3'd0; step(); step();
      INP_i = 3'd7; step(); step();
    end
    strobe_mode(2'd3);
    step(); step(); step();
    rand_steps(30);
    strobe_delay(5'd3);
    rand_steps(10);
    strobe_mode(2'd3);
    rand_steps(15);

    // long delay, restart during priming, reset with pulses in flight
    FUNC = $urandom();
    strobe_delay(5'd31);
    rand_steps(40);
    strobe_delay(5'd7);
    rand_steps(3);
    strobe_delay(5'd31);
    rand_steps(45);
    reset_i = 1'b1; DELAY_wstb = 1'b1; MODE_wstb = 1'b1; DELAY = 5'd31;
    INP_i = NUM_IN'($urandom()); step();
    reset_i = 1'b0; DELAY_wstb = 1'b0; MODE_wstb = 1'b0;
    rand_steps(45);

    // alternating pattern through a full-depth delay across pointer wraps
    FUNC = 32'h02;
    strobe_mode(2'd0);
    INP_i = 3'd0; step(); step(); step();
    strobe_delay(5'd31);
    for (int i = 1; i <= 200; i++) begin
      INP_i = NUM_IN'(i & 1);
      step();
      if (i >= 32) begin
        tests++;
        assert (OUT_o === inp_h[cyc-33]) else begin
          fails++;
          $error("FAIL shift33 edge=%0d got=%b exp=%b", cyc, OUT_o, inp_h[cyc-33]);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
